// File: rtl/vote_vector_sequencer.sv
// rtl/vote_vector_sequencer.sv - exhaustive self-test sequencer for a 1-bit combinational voter
// Optional build macro CONTINUE_ON_FAIL_EN: keep sweeping after a mismatch instead of stopping.
module vote_vector_sequencer #(
  parameter int N_IN    = 3,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  output logic [N_IN-1:0] vec,
  input  logic            dut_r,
  input  logic            ref_r,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_got,
  output logic            fail_exp,
  output logic [N_IN:0]   fail_cnt
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
  logic            fail_got_q, fail_got_d;
  logic            fail_exp_q, fail_exp_d;
  logic [N_IN:0]   fail_cnt_q, fail_cnt_d;

  logic [TW-1:0] timer_inc;
  logic          mismatch;
  logic          last_vec;

  assign timer_inc = timer_q + TW'(1);
  assign mismatch  = dut_r != ref_r;
  assign last_vec  = &vec_q;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    timer_d    = timer_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    fail_vec_d = fail_vec_q;
    fail_got_d = fail_got_q;
    fail_exp_d = fail_exp_q;
    fail_cnt_d = fail_cnt_q;

    // The abort timer runs in every busy cycle, independent of hold.
    if (busy_q) begin
      timer_d = timer_inc;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d      = '0;
          settle_d   = '0;
          timer_d    = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          fail_vec_d = '0;
          fail_got_d = 1'b0;
          fail_exp_d = 1'b0;
          fail_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (timer_inc >= TW'(TIMEOUT)) begin
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (!hold) begin
          settle_d = settle_q + SW'(1);
          if (settle_q == SW'(SETTLE - 1)) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          if (fail_cnt_q == '0) begin
            fail_vec_d = vec_q;
            fail_got_d = dut_r;
            fail_exp_d = ref_r;
          end
          if (!(&fail_cnt_q)) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
          end
        end
`ifdef CONTINUE_ON_FAIL_EN
        if (last_vec) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == '0);
          state_d = S_DONE;
        end else begin
          vec_d    = vec_q + 1'b1;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
`else
        if (mismatch || last_vec) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = !mismatch;
          state_d = S_DONE;
        end else begin
          vec_d    = vec_q + 1'b1;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      settle_q   <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_vec_q <= '0;
      fail_got_q <= 1'b0;
      fail_exp_q <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      fail_vec_q <= fail_vec_d;
      fail_got_q <= fail_got_d;
      fail_exp_q <= fail_exp_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign vec      = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign fail_vec = fail_vec_q;
  assign fail_got = fail_got_q;
  assign fail_exp = fail_exp_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_vote_vector_sequencer.sv
// tb/tb_vote_vector_sequencer.sv - scoreboard bench for vote_vector_sequencer (default parameters)
module tb_vote_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       hold;
  logic [2:0] vec;
  logic       dut_r;
  logic       ref_r;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [2:0] fail_vec;
  logic       fail_got;
  logic       fail_exp;
  logic [3:0] fail_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic stuck0 = 1'b0;

  typedef struct {
    int         edge_n;
    logic       pass;
    logic       timeout;
    logic [2:0] fail_vec;
    logic       fail_got;
    logic       fail_exp;
    logic [3:0] fail_cnt;
    logic [2:0] vec;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  vote_vector_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hold     (hold),
    .vec      (vec),
    .dut_r    (dut_r),
    .ref_r    (ref_r),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .fail_vec (fail_vec),
    .fail_got (fail_got),
    .fail_exp (fail_exp),
    .fail_cnt (fail_cnt)
  );

  // Golden majority voter; the unit under test is either the same or stuck at 0.
  always_comb begin
    ref_r = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    dut_r = stuck0 ? 1'b0 : ref_r;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_outs"},
              {21'd0, vec, busy, done, pass, timeout, fail_vec, fail_got, fail_exp, fail_cnt},
              32'd0);
  endtask

  // Pulse start for one edge (edge 0), then count edges until done rises.
  // restart_at/hold_at: edge number after which start is re-pulsed / hold is raised (-1 = never).
  task automatic run(input string tag, input int restart_at, input int hold_at);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    check_val({tag, "_clr"}, {24'd0, done, pass, timeout, fail_cnt, vec == 3'd0}, 32'd1);
    while (!done && n < 200) begin
      if (n == restart_at) start = 1'b1;
      if (n == hold_at) hold = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    hold = 1'b0;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_done_edge"}, n, e.edge_n);
      check_val({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      check_val({tag, "_pass"}, {31'd0, pass}, {31'd0, e.pass});
      check_val({tag, "_timeout"}, {31'd0, timeout}, {31'd0, e.timeout});
      check_val({tag, "_fail_vec"}, {29'd0, fail_vec}, {29'd0, e.fail_vec});
      check_val({tag, "_fail_ge"}, {30'd0, fail_got, fail_exp}, {30'd0, e.fail_got, e.fail_exp});
      check_val({tag, "_fail_cnt"}, {28'd0, fail_cnt}, {28'd0, e.fail_cnt});
      check_val({tag, "_vec"}, {29'd0, vec}, {29'd0, e.vec});
    end
  endtask

  function automatic exp_t mk(int ed, logic p, logic t, logic [2:0] fv, logic g, logic x,
                              logic [3:0] c, logic [2:0] v);
    exp_t e;
    e.edge_n = ed; e.pass = p; e.timeout = t; e.fail_vec = fv;
    e.fail_got = g; e.fail_exp = x; e.fail_cnt = c; e.vec = v;
    return e;
  endfunction

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean sweep: vectors 0..7, three edges each.
    stuck0 = 1'b0;
    sb_q.push_back(mk(24, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd7));
    run("clean", -1, -1);

    // Stuck-at-0 unit: first mismatch at 011.
    stuck0 = 1'b1;
`ifdef CONTINUE_ON_FAIL_EN
    sb_q.push_back(mk(24, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 4'd4, 3'd7));
`else
    sb_q.push_back(mk(12, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 4'd1, 3'd3));
`endif
    run("stuck0", -1, -1);
    stuck0 = 1'b0;

    // Stall from edge 5 onward: vec 1 was applied at edge 3; timer aborts at edge 64.
    sb_q.push_back(mk(64, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0, 3'd1));
    run("hold", -1, 4);

    // start re-pulsed mid-run is ignored.
    sb_q.push_back(mk(24, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd7));
    run("restart", 10, -1);

    // Async reset while vec == 100.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (vec != 3'd4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("rst_reach_vec4", {31'd0, vec == 3'd4}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;

    sb_q.push_back(mk(24, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 3'd7));
    run("after_rst", -1, -1);

    repeat (3) @(posedge clk);
    #1;
    check_val("done_level", {30'd0, done, pass}, 32'd3);
    check_val("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vote_vector_sequencer.md
Name: vote_vector_sequencer

Overview:
- Hardware self-test sequencer for a combinational voter such as majority3.
- Steps through all 2^N_IN input vectors and drives them to a unit under test and a golden model at the same time.
- Waits a settle window for each vector, then compares the two 1-bit results.
- Reports pass/fail, the first failing vector, and a timeout. This is an on-chip equivalent of the exhaustive judge bench.

Parameters:
N_IN, 3, vector width (1..8); number of vectors = 2^N_IN
SETTLE, 2, cycles a vector is held before compare (>=1)
TIMEOUT, 64, max busy cycles before abort (> 2^N_IN*(SETTLE+1) for nominal runs)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  run request, sampled in IDLE/DONE
hold  in  1  stall: freezes settle counter and vector; timeout timer keeps running
vec  out  N_IN  vector driven to both voters (bit N_IN-1 = a)
dut_r  in  1  unit-under-test result
ref_r  in  1  golden-model result
busy  out  1  run in progress
done  out  1  run finished; level, held until next start
pass  out  1  valid when done: all vectors matched, no timeout
timeout  out  1  valid when done: run aborted by timer
fail_vec  out  N_IN  first mismatching vector
fail_got  out  1  dut_r at first mismatch
fail_exp  out  1  ref_r at first mismatch
fail_cnt  out  N_IN+1  mismatch count

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0: vec, busy, done, pass, timeout, fail_vec, fail_got, fail_exp, fail_cnt. Timer and settle counter are also cleared.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE, start=1 at an edge:
  - vec<=0, settle_cnt<=0, timer<=0.
  - Clear done, pass, timeout, fail_* and fail_cnt.
  - busy<=1, go to SETTLE.
- SETTLE:
  - hold=1: no change.
  - Otherwise settle_cnt increments; when settle_cnt==SETTLE-1, go to CHECK.
- CHECK (one cycle; hold ignored):
  - Mismatch = dut_r != ref_r.
  - On mismatch: if fail_cnt==0, latch fail_vec=vec, fail_got=dut_r, fail_exp=ref_r. fail_cnt saturating +1. Go to DONE with pass=0.
  - No mismatch and vec==all-ones: go to DONE with pass=1.
  - Otherwise: vec<=vec+1, settle_cnt<=0, go to SETTLE.
- Timing:
  - Vector k is applied at edge k*(SETTLE+1) after the start edge.
  - A clean run asserts done at edge 2^N_IN*(SETTLE+1). With defaults that is edge 24, so busy is high for 24 cycles.
- Timer:
  - Increments every busy cycle.
  - If the timer would reach TIMEOUT in SETTLE: go to DONE with timeout=1, pass=0.
  - If completion and timeout fall on the same edge, completion wins and timeout=0.
- DONE:
  - busy=0, done=1. vec holds its last value; results hold.
  - start restarts the run.
- start while busy: ignored.
- Reset mid-run: immediate return to IDLE with all outputs 0; no partial results are retained.
- vec never wraps: the increment happens only when vec != all-ones.

Optional Feature:
CONTINUE_ON_FAIL_EN
- Defined: a mismatch in CHECK does not end the run.
  - The sequencer records the first failure, increments fail_cnt (saturating) and continues through all vectors.
  - After the last vector it goes to DONE with pass=(fail_cnt==0 after the final check).
  - Run length equals a clean run.
- Undefined: stop at the first mismatch, as described in Behaviour; fail_cnt is only ever 0 or 1.

Test Plan:
- Correct voter (dut_r=ref_r=majority(vec)), one-cycle start pulse -> busy for 24 cycles; done=1, pass=1, timeout=0, fail_cnt=0, vec=3'b111.
- dut_r stuck at 0, macro undefined -> done at edge 12; pass=0, fail_vec=3'b011, fail_got=0, fail_exp=1, fail_cnt=1.
- dut_r stuck at 0, CONTINUE_ON_FAIL_EN defined -> done at edge 24; pass=0, fail_vec=3'b011, fail_cnt=4 (failures at 011, 101, 110, 111).
- hold=1 from cycle 5 onward, TIMEOUT=64 -> done=1, timeout=1, pass=0 at edge 64; vec frozen at the value applied before the stall.
- rst pulsed while vec=3'b100 -> all outputs 0 asynchronously. A new start then applies 3'b000 first and completes pass=1 at edge 24.
- start re-pulsed at cycle 10 of a run -> ignored, done still at edge 24. start pulsed in DONE -> results cleared, new run begins.
